signed_seq_multiplier: RTL and testbench



---
 rtl/signed_seq_multiplier_pkg.sv | 16 +
 rtl/signed_seq_multiplier_magnitude_split.sv | 20 ++
 rtl/signed_seq_multiplier.sv | 112 +++++++++++
 tb/tb_signed_seq_multiplier.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/signed_seq_multiplier_pkg.sv
// Shared definitions for the signed sequential multiplier.
// - state_t   : FSM state encoding (IDLE / RUN / FINISH)
// - cnt_width : bit width needed for a counter that holds values 0..n
package signed_seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/signed_seq_multiplier_magnitude_split.sv
// Splits an N-bit two's-complement value into an unsigned magnitude and a
// sign flag. Purely combinational.
// Ports:
//   x   : signed operand
//   mag : |x| as unsigned N bits (-2^(N-1) maps to 2^(N-1))
//   neg : sign bit of x
module magnitude_split #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] x,
  output logic [N-1:0] mag,
  output logic         neg
);

  always_comb begin
    neg = x[N-1];
    mag = x[N-1] ? (~x + N'(1)) : x;
  end

endmodule

// File: rtl/signed_seq_multiplier.sv
// Multi-cycle signed multiplier. Operand magnitudes are multiplied with a
// one-bit-per-cycle shift-add loop; the sign is applied when the result is
// registered.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request, sampled only while idle
//   multiplicand : signed operand A (N bits)
//   multiplier   : signed operand B (N bits)
//   busy         : operation in progress (RUN or FINISH)
//   done         : one-cycle pulse, product valid
//   product      : signed 2N-bit A*B, held until the next result
module signed_seq_multiplier
  import signed_seq_multiplier_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned CW = cnt_width(N);

  state_t state, next_state;

  logic [N-1:0]   a_mag, b_mag;
  logic           a_neg, b_neg;
  logic [N-1:0]   a_mag_q;
  logic           sign_q;
  logic [2*N:0]   work;      // {acc_hi (N+1), mlt (N)}
  logic [CW-1:0]  cnt;
  logic [N:0]     acc_sum;
  logic [2*N-1:0] mag_prod;
  logic           load, step, finish;

  magnitude_split #(.N(N)) u_split_a (
    .x   (multiplicand),
    .mag (a_mag),
    .neg (a_neg)
  );

  magnitude_split #(.N(N)) u_split_b (
    .x   (multiplier),
    .mag (b_mag),
    .neg (b_neg)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; the counter value 1 marks the last RUN edge
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == CW'(1)) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / control decode (state register only, no input-to-output path)
  always_comb begin
    busy   = (state != IDLE);
    load   = (state == IDLE) && start;
    step   = (state == RUN);
    finish = (state == FINISH);
  end

  always_comb begin
    acc_sum  = work[0] ? (work[2*N:N] + {1'b0, a_mag_q}) : work[2*N:N];
    mag_prod = work[2*N-1:0];
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mag_q <= '0;
      sign_q  <= 1'b0;
      work    <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a_mag_q <= a_mag;
        sign_q  <= a_neg ^ b_neg;
        work    <= {{(N+1){1'b0}}, b_mag};
        cnt     <= CW'(N);
      end
      if (step) begin
        work <= {acc_sum, work[N-1:0]} >> 1;
        cnt  <= cnt - CW'(1);
      end
      if (finish) begin
        // Negating a zero magnitude yields zero, so no negative zero.
        product <= sign_q ? (~mag_prod + (2*N)'(1)) : mag_prod;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_signed_seq_multiplier.sv
module tb_signed_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=64 instance
  logic         rst64, start64, busy64, done64;
  logic [63:0]  a64, b64;
  logic [127:0] prod64;

  // N=8 instance
  logic         rst8, start8, busy8, done8;
  logic [7:0]   a8, b8;
  logic [15:0]  prod8;

  signed_seq_multiplier #(.N(64)) u_dut64 (
    .clk          (clk),
    .rst          (rst64),
    .start        (start64),
    .multiplicand (a64),
    .multiplier   (b64),
    .busy         (busy64),
    .done         (done64),
    .product      (prod64)
  );

  signed_seq_multiplier #(.N(8)) u_dut8 (
    .clk          (clk),
    .rst          (rst8),
    .start        (start8),
    .multiplicand (a8),
    .multiplier   (b8),
    .busy         (busy8),
    .done         (done8),
    .product      (prod8)
  );

  int total = 0;
  int bad   = 0;

  logic [127:0] q64[$];
  logic [15:0]  q8[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mul64(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] ea, eb;
    ea = {{64{a[63]}}, a};
    eb = {{64{b[63]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] ea, eb;
    ea = {{8{a[7]}}, a};
    eb = {{8{b[7]}}, b};
    return ea * eb;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? done8 : done64;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy8 : busy64;
  endfunction

  // sel=1 drives the N=8 instance, sel=0 the N=64 instance
  task automatic start_op(input bit sel, input logic [63:0] a, input logic [63:0] b);
    if (sel) begin
      a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
      q8.push_back(mul8(a[7:0], b[7:0]));
    end else begin
      a64 = a; b64 = b; start64 = 1'b1;
      q64.push_back(mul64(a, b));
    end
    tick;
    start8  = 1'b0;
    start64 = 1'b0;
  endtask

  // Waits (bounded) for done; 'first' cycles since acceptance already elapsed.
  task automatic wait_done(input bit sel, input string tag, input int first, input int lat);
    int cyc = first;
    int busy_n = 0;
    logic [127:0] exp;
    while (get_done(sel) !== 1'b1 && cyc < 400) begin
      if (get_busy(sel) === 1'b1) busy_n++;
      tick;
      cyc++;
    end
    check({tag, " latency"}, 128'(cyc), 128'(lat));
    check({tag, " busy_cycles"}, 128'(busy_n), 128'(lat - first));
    check({tag, " busy_at_done"}, 128'(get_busy(sel)), 128'(0));
    if (sel) begin
      check({tag, " queue_nonempty"}, 128'(q8.size() != 0), 128'(1));
      exp = (q8.size() != 0) ? {112'b0, q8.pop_front()} : '1;
      check({tag, " product"}, {112'b0, prod8}, exp);
    end else begin
      check({tag, " queue_nonempty"}, 128'(q64.size() != 0), 128'(1));
      exp = (q64.size() != 0) ? q64.pop_front() : '1;
      check({tag, " product"}, prod64, exp);
    end
  endtask

  initial begin
    rst64 = 1'b1; rst8 = 1'b1;
    start64 = 1'b0; start8 = 1'b0;
    a64 = '0; b64 = '0; a8 = '0; b8 = '0;
    repeat (3) tick;
    check("rst64 busy", 128'(busy64), 128'(0));
    check("rst64 done", 128'(done64), 128'(0));
    check("rst64 product", prod64, 128'(0));
    check("rst8 busy", 128'(busy8), 128'(0));
    check("rst8 done", 128'(done8), 128'(0));
    check("rst8 product", {112'b0, prod8}, 128'(0));
    rst64 = 1'b0; rst8 = 1'b0;
    tick;

    // N=64: 3 * -5, operands change after acceptance
    start_op(0, 64'd3, 64'(-5));
    a64 = 64'd12345; b64 = 64'd777;
    check("a3b-5 busy_after_accept", 128'(busy64), 128'(1));
    wait_done(0, "a3b-5", 0, 65);
    check("a3b-5 value", prod64, {{124{1'b1}}, 4'b0001});
    tick;
    check("a3b-5 done_pulse_end", 128'(done64), 128'(0));
    check("a3b-5 product_hold", prod64, {{124{1'b1}}, 4'b0001});

    // N=64: most-negative operands
    start_op(0, 64'h8000_0000_0000_0000, '1);
    wait_done(0, "min*-1", 0, 65);
    check("min*-1 value", prod64, {64'h0, 64'h8000_0000_0000_0000});
    tick;
    start_op(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    wait_done(0, "min*min", 0, 65);
    check("min*min value", prod64, {2'b01, 126'b0});
    tick;

    // N=8: zero operand, and -128*127
    start_op(1, 64'd0, 64'(-7));
    wait_done(1, "0*-7", 0, 9);
    check("0*-7 value", {112'b0, prod8}, 128'(0));
    tick;
    start_op(1, 64'(-128), 64'd127);
    wait_done(1, "-128*127", 0, 9);
    check("-128*127 value", {112'b0, prod8}, 128'h0000_C080);
    tick;

    // N=8: ignored start while busy, then back-to-back start in the done cycle
    start_op(1, 64'd6, 64'd7);
    tick;
    tick;
    a8 = 8'd2; b8 = 8'd2; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    wait_done(1, "b2b_first", 3, 9);
    start_op(1, 64'(-4), 64'd5);
    check("b2b done_pulse_end", 128'(done8), 128'(0));
    check("b2b busy_restart", 128'(busy8), 128'(1));
    wait_done(1, "b2b_second", 0, 9);
    tick;

    // N=8: reset aborts mid-operation
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    repeat (3) tick;
    #2 rst8 = 1'b1;
    #1;
    check("abort busy", 128'(busy8), 128'(0));
    check("abort done", 128'(done8), 128'(0));
    check("abort product", {112'b0, prod8}, 128'(0));
    tick;
    rst8 = 1'b0;
    tick;
    start_op(1, 64'(-9), 64'd9);
    wait_done(1, "after_abort", 0, 9);
    check("after_abort value", {112'b0, prod8}, 128'h0000_FFAF);
    tick;
    check("after_abort done_pulse_end", 128'(done8), 128'(0));

    check("queues_drained", 128'(q8.size() + q64.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
